// File: rtl/bsg_cache_nb_dma_arbiter.sv
`default_nettype none
// =============================================================================
// bsg_cache_nb_dma_arbiter: shares one DMA channel among non-blocking vcaches.
// Revision: 1.0
// =============================================================================
module bsg_cache_nb_dma_arbiter #(
  parameter int num_dma_p         = 4,
  parameter int dma_addr_width_p  = 32,
  parameter int dma_mask_width_p  = 8,
  parameter int dma_burst_len_p   = 8,
  parameter int dma_data_width_p  = 64,
  parameter int vcache_mshr_els_p = 4,
  parameter int max_reads_p       = 8,
  localparam int MSHR_W = (vcache_mshr_els_p > 1) ? $clog2(vcache_mshr_els_p) : 1,
  localparam int PKT_W  = 1 + dma_mask_width_p + MSHR_W + dma_addr_width_p,
  localparam int ID_W   = (num_dma_p > 1) ? $clog2(num_dma_p) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,

  input  logic [num_dma_p*PKT_W-1:0]            cache_dma_pkt_i,
  input  logic [num_dma_p-1:0]                  cache_dma_pkt_v_i,
  output logic [num_dma_p-1:0]                  cache_dma_pkt_yumi_o,

  output logic [num_dma_p*dma_data_width_p-1:0] cache_dma_data_o,
  output logic [num_dma_p*MSHR_W-1:0]           cache_dma_mshr_id_o,
  output logic [num_dma_p-1:0]                  cache_dma_data_v_o,
  input  logic [num_dma_p-1:0]                  cache_dma_data_ready_and_i,

  input  logic [num_dma_p*dma_data_width_p-1:0] cache_dma_data_i,
  input  logic [num_dma_p-1:0]                  cache_dma_data_v_i,
  output logic [num_dma_p-1:0]                  cache_dma_data_yumi_o,

  output logic [PKT_W-1:0]                      mem_dma_pkt_o,
  output logic                                  mem_dma_pkt_v_o,
  input  logic                                  mem_dma_pkt_yumi_i,

  input  logic [dma_data_width_p-1:0]           mem_dma_data_i,
  input  logic [MSHR_W-1:0]                     mem_dma_mshr_id_i,
  input  logic                                  mem_dma_data_v_i,
  output logic                                  mem_dma_data_ready_and_o,

  output logic [dma_data_width_p-1:0]           mem_dma_data_o,
  output logic                                  mem_dma_data_v_o,
  input  logic                                  mem_dma_data_yumi_i
);

  localparam int CNT_W   = (dma_burst_len_p > 1) ? $clog2(dma_burst_len_p) : 1;
  localparam int FIFO_AW = (max_reads_p > 1) ? $clog2(max_reads_p) : 1;
  localparam int FIFO_CW = $clog2(max_reads_p + 1);
  localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(dma_burst_len_p - 1);
  localparam logic [ID_W-1:0]    LAST_ID    = ID_W'(num_dma_p - 1);
  localparam logic [FIFO_AW-1:0] LAST_SLOT  = FIFO_AW'(max_reads_p - 1);
  localparam logic [FIFO_CW-1:0] FIFO_DEPTH = FIFO_CW'(max_reads_p);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    EVICT = 1'b1
  } state_e;

  state_e state, state_next;

  logic [PKT_W-1:0]            pkt        [num_dma_p];
  logic [dma_data_width_p-1:0] evict_data [num_dma_p];
  logic [num_dma_p-1:0]        eligible;

  logic [ID_W-1:0]  rr_ptr, grant_id, lock_id, head_id;
  logic             grant_v;
  logic [CNT_W-1:0] evict_cnt, fill_cnt;
  logic             evict_last, fill_last;
  logic             pkt_hs, pkt_write, read_push, evict_hs, fill_hs, fifo_pop;

  logic [ID_W-1:0]    fifo_mem [max_reads_p];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_CW-1:0] fifo_cnt;
  logic               fifo_full, fifo_empty;

  // The write bit sits at the packet MSB; a read needs a free id slot to be eligible.
  for (genvar i = 0; i < num_dma_p; i++) begin : g_req
    assign pkt[i]        = cache_dma_pkt_i[i*PKT_W +: PKT_W];
    assign evict_data[i] = cache_dma_data_i[i*dma_data_width_p +: dma_data_width_p];
    assign eligible[i]   = cache_dma_pkt_v_i[i] & (pkt[i][PKT_W-1] | ~fifo_full);
  end

  function automatic logic [ID_W-1:0] wrap_id(input int v);
    return ID_W'(v % num_dma_p);
  endfunction

  always_comb begin
    grant_id = rr_ptr;
    grant_v  = 1'b0;
    for (int k = num_dma_p - 1; k >= 0; k--) begin
      if (eligible[wrap_id(int'(rr_ptr) + k)]) begin
        grant_v  = 1'b1;
        grant_id = wrap_id(int'(rr_ptr) + k);
      end
    end
  end

  assign pkt_write  = pkt[grant_id][PKT_W-1];
  assign pkt_hs     = (state == IDLE) & grant_v & mem_dma_pkt_yumi_i;
  assign read_push  = pkt_hs & ~pkt_write;
  assign evict_hs   = (state == EVICT) & mem_dma_data_yumi_i;
  assign evict_last = (evict_cnt == LAST_BEAT);

  always_comb begin
    state_next            = state;
    mem_dma_pkt_v_o       = 1'b0;
    mem_dma_pkt_o         = '0;
    cache_dma_pkt_yumi_o  = '0;
    mem_dma_data_v_o      = 1'b0;
    mem_dma_data_o        = '0;
    cache_dma_data_yumi_o = '0;
    if (!reset_i) begin
      case (state)
        IDLE: begin
          mem_dma_pkt_v_o                = grant_v;
          mem_dma_pkt_o                  = pkt[grant_id];
          cache_dma_pkt_yumi_o[grant_id] = grant_v & mem_dma_pkt_yumi_i;
          if (pkt_hs & pkt_write) state_next = EVICT;
        end
        EVICT: begin
          mem_dma_data_v_o               = cache_dma_data_v_i[lock_id];
          mem_dma_data_o                 = evict_data[lock_id];
          cache_dma_data_yumi_o[lock_id] = mem_dma_data_yumi_i;
          if (evict_hs & evict_last) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lock_id   <= '0;
      evict_cnt <= '0;
    end else begin
      state <= state_next;
      if (pkt_hs) begin
        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        if (pkt_write) lock_id <= grant_id;
      end
      if (evict_hs) evict_cnt <= evict_last ? '0 : evict_cnt + 1'b1;
    end
  end

  // Outstanding-read id FIFO: its head selects which cache receives fill beats.
  assign fifo_full  = (fifo_cnt == FIFO_DEPTH);
  assign fifo_empty = (fifo_cnt == '0);
  assign head_id    = fifo_mem[rd_ptr];
  assign fill_last  = (fill_cnt == LAST_BEAT);
  assign fill_hs    = mem_dma_data_ready_and_o & mem_dma_data_v_i;
  assign fifo_pop   = fill_hs & fill_last;

  always_ff @(posedge clk_i) begin
    if (read_push) fifo_mem[wr_ptr] <= grant_id;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      fill_cnt <= '0;
    end else begin
      if (read_push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      if (read_push & ~fifo_pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (fifo_pop & ~read_push) fifo_cnt <= fifo_cnt - 1'b1;
      if (fill_hs) fill_cnt <= fill_last ? '0 : fill_cnt + 1'b1;
    end
  end

  assign mem_dma_data_ready_and_o = ~reset_i & ~fifo_empty & cache_dma_data_ready_and_i[head_id];

  for (genvar i = 0; i < num_dma_p; i++) begin : g_fill
    assign cache_dma_data_v_o[i] = ~reset_i & ~fifo_empty & mem_dma_data_v_i & (head_id == ID_W'(i));
    assign cache_dma_data_o[i*dma_data_width_p +: dma_data_width_p] = reset_i ? '0 : mem_dma_data_i;
    assign cache_dma_mshr_id_o[i*MSHR_W +: MSHR_W] = reset_i ? '0 : mem_dma_mshr_id_i;
  end

  fill_without_read_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(mem_dma_data_v_i && fifo_empty));

endmodule
`default_nettype wire

// File: doc/bsg_cache_nb_dma_arbiter.md
Name: bsg_cache_nb_dma_arbiter

Overview:
- Shares one bsg_cache_nb DMA channel among num_dma_p non-blocking vcaches.
- Arbitrates DMA packets round-robin and locks the grant for a write's evict burst.
- Routes returning fill bursts back to the issuing cache using an in-order FIFO of requester ids.
- Sits between the vcaches and a single DMA endpoint: a wormhole adapter, bsg_cache_nb_to_axi or test DRAM.

Parameters:
- num_dma_p, 4, number of cache requesters (>=1).
- dma_addr_width_p, 32, byte address width in the DMA packet.
- dma_mask_width_p, 8, mask width in the DMA packet (block size in words).
- dma_burst_len_p, 8, data beats per fill or evict transfer (>=1).
- dma_data_width_p, 64, data beat width.
- vcache_mshr_els_p, 4, MSHR entries per cache; mshr_w = SAFE_CLOG2(vcache_mshr_els_p).
- max_reads_p, 8, depth of the outstanding-read id FIFO.
- Derived: pkt_w = bsg_cache_nb_dma_pkt_width(dma_addr_width_p, dma_mask_width_p, vcache_mshr_els_p); id_w = SAFE_CLOG2(num_dma_p).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; one clock; reset is synchronous and active-high.
- cache_dma_pkt_i  in  num_dma_p*pkt_w  per-cache DMA packet.
- cache_dma_pkt_v_i  in  num_dma_p  packet valid.
- cache_dma_pkt_yumi_o  out  num_dma_p  packet consumed.
- cache_dma_data_o  out  num_dma_p*dma_data_width_p  fill data to cache.
- cache_dma_mshr_id_o  out  num_dma_p*mshr_w  fill MSHR tag.
- cache_dma_data_v_o  out  num_dma_p  fill valid.
- cache_dma_data_ready_and_i  in  num_dma_p  fill ready.
- cache_dma_data_i  in  num_dma_p*dma_data_width_p  evict data from cache.
- cache_dma_data_v_i  in  num_dma_p  evict valid.
- cache_dma_data_yumi_o  out  num_dma_p  evict consumed.
- mem_dma_pkt_o  out  pkt_w  arbitrated packet.
- mem_dma_pkt_v_o  out  1  packet valid.
- mem_dma_pkt_yumi_i  in  1  packet consumed.
- mem_dma_data_i  in  dma_data_width_p  fill data.
- mem_dma_mshr_id_i  in  mshr_w  fill tag.
- mem_dma_data_v_i  in  1  fill valid.
- mem_dma_data_ready_and_o  out  1  fill ready.
- mem_dma_data_o  out  dma_data_width_p  evict data.
- mem_dma_data_v_o  out  1  evict valid.
- mem_dma_data_yumi_i  in  1  evict consumed.

Behaviour:
- Reset: while reset_i=1 all v, yumi and ready outputs are 0 and data outputs are 0. Send FSM goes to IDLE, both beat counters clear, id FIFO empties, RR pointer resets to requester 0. Reset mid-burst abandons the burst; no recovery is attempted.
- Eligibility: requester i is eligible when cache_dma_pkt_v_i[i]=1 and NOT (pkt.write_not_read=0 AND FIFO full). Full blocks a read even in a cycle where the FIFO pops; there is no bypass.
- Send FSM, IDLE:
  - RR arbiter over eligible requesters; mem_dma_pkt_v_o = |eligible; mem_dma_pkt_o = the granted packet, passed through unmodified.
  - The RR pointer advances only on mem_dma_pkt_yumi_i, so the grant is stable while requests are stable.
  - On yumi: cache_dma_pkt_yumi_o[g]=1 in the same cycle.
  - Read: push g into the FIFO; stay in IDLE.
  - Write: latch g as lock_id, go to EVICT.
  - Zero-latency combinational path from v to yumi is permitted.
- Send FSM, EVICT:
  - No packet arbitration; mem_dma_pkt_v_o=0.
  - mem_dma_data_o/v_o come from cache_dma_data_i/v_i[lock_id].
  - cache_dma_data_yumi_o[lock_id] = mem_dma_data_yumi_i.
  - Each yumi increments evict_cnt; the yumi at evict_cnt = dma_burst_len_p-1 clears the counter and returns to IDLE.
  - Evict data from non-locked caches is ignored (yumi 0).
- Fill path (independent of the send FSM, runs concurrently):
  - head = FIFO head.
  - mem_dma_data_ready_and_o = ~empty & cache_dma_data_ready_and_i[head].
  - cache_dma_data_v_o[head] = ~empty & mem_dma_data_v_i.
  - cache_dma_data_o and cache_dma_mshr_id_o are broadcast to all caches; only head sees valid.
  - On each handshake fill_cnt++; the handshake at fill_cnt = dma_burst_len_p-1 clears the counter and pops the FIFO.
  - Fill beats arriving while the FIFO is empty are not accepted (ready 0); simulation asserts an error.
  - Fills must return in read-issue order.
- Simultaneous events:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Last evict beat and a new packet in the same cycle: the new packet is arbitrated next cycle.
- dma_burst_len_p=1: the counter is constant 0 and every handshake is the last beat.

Test Plan:
- Caches 0 and 2 post reads simultaneously, mem yumis every cycle -> grants 0 then 2; FIFO holds [0,2]; 8 fill beats route to cache 0 with mshr tag passthrough, next 8 to cache 2.
- Cache 1 posts a write, then cache 3 a read -> write is granted, 8 evict beats from cache 1 are forwarded, cache 3's pkt is held with no grant until the 8th evict yumi, then granted the cycle after.
- 8 reads outstanding (max_reads_p=8) -> a 9th read gets no grant while a write from another cache is still granted; after one fill burst completes, the read is granted.
- Head cache holds cache_dma_data_ready_and_i=0 for 3 cycles mid-burst -> mem_dma_data_ready_and_o=0 for those cycles, no beat is lost, and fill_cnt holds.
- All 4 caches continuously request reads -> grant order 0,1,2,3,0 with no starvation.
- Assert reset_i during EVICT beat 4 -> next cycle all outputs are 0, FSM is IDLE and the FIFO is empty; a new read is granted normally afterwards.
